// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: stall/flush/redirect generation for load-use,
// I/D-cache misses and taken branches, with a pending-redirect register and perf counters.
module hazard_stall_ctrl #(
  parameter int CNT_W = 32,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             rs1_usedD,
  input  logic             rs2_usedD,
  input  logic [4:0]       rdE,
  input  logic             memreadE,
  input  logic             branch_takenE,
  input  logic [XLEN-1:0]  branch_targetE,
  input  logic             icache_ready,
  input  logic             dcache_reqM,
  input  logic             dcache_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {RUN = 2'd0, IWAIT = 2'd1, IWAIT_REDIR = 2'd2, DWAIT = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic              pend_v_q, pend_v_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mstall, istall, lu, br_fire;

  assign mstall = dcache_reqM & ~dcache_ready;
  assign istall = ~icache_ready;
  assign lu     = memreadE & (rdE != 5'd0) &
                  ((rs1_usedD & (rdE == rs1D)) | (rs2_usedD & (rdE == rs2D)));

  always_comb begin
    stallF         = 1'b0;
    stallD         = 1'b0;
    stallE         = 1'b0;
    stallM         = 1'b0;
    flushD         = 1'b0;
    flushE         = 1'b0;
    flushW         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    br_fire        = 1'b0;
    pend_v_d       = pend_v_q;
    pend_pc_d      = pend_pc_q;

    if (rst) begin
      pend_v_d  = 1'b0;
      pend_pc_d = '0;
    end else if (mstall) begin
      // Whole pipe frozen; E is held so branch/load-use re-evaluate on release.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (pend_v_q && icache_ready) begin
      redirect_valid = 1'b1;
      redirect_pc    = pend_pc_q;
      flushD         = 1'b1;
      pend_v_d       = 1'b0;
    end else if (branch_takenE && !pend_v_q && !istall) begin
      redirect_valid = 1'b1;
      redirect_pc    = branch_targetE;
      flushD         = 1'b1;
      flushE         = 1'b1;
      br_fire        = 1'b1;
    end else if (branch_takenE && !pend_v_q) begin
      // Fetch busy: squash now, remember the target until the miss returns.
      flushD    = 1'b1;
      flushE    = 1'b1;
      stallF    = 1'b1;
      pend_v_d  = 1'b1;
      pend_pc_d = branch_targetE;
      br_fire   = 1'b1;
    end else if (lu) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (istall) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end

    if (rst)           state_d = RUN;
    else if (mstall)   state_d = DWAIT;
    else if (pend_v_d) state_d = IWAIT_REDIR;
    else if (istall)   state_d = IWAIT;
    else               state_d = RUN;

    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    flush_cnt_d = flush_cnt_q;
    if (br_fire && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pend_v_q    <= 1'b0;
      pend_pc_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_v_q    <= pend_v_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a priority-table model.
module tb_hazard_stall_ctrl;
  localparam int CNT_W = 6;
  localparam int XLEN  = 32;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic rst, rs1_usedD, rs2_usedD, memreadE, branch_takenE, icache_ready, dcache_reqM, dcache_ready;
  logic [4:0] rs1D, rs2D, rdE;
  logic [XLEN-1:0] branch_targetE;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0] state;

  hazard_stall_ctrl #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD), .rs2_usedD(rs2_usedD),
    .rdE(rdE), .memreadE(memreadE), .branch_takenE(branch_takenE), .branch_targetE(branch_targetE),
    .icache_ready(icache_ready), .dcache_reqM(dcache_reqM), .dcache_ready(dcache_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending redirect, state and counters as plain integers.
  bit m_valid = 0;
  bit m_pend = 0, n_pend = 0;
  int m_pc = 0, n_pc = 0;
  int m_state = 0, n_state = 0;
  int m_scnt = 0, n_scnt = 0;
  int m_fcnt = 0, n_fcnt = 0;
  bit n_valid = 0;

  int  c;
  bit  ms, is, lu;
  bit  e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fW, e_rv;
  int  e_pc;

  always @(negedge clk) begin
    ms = dcache_reqM && !dcache_ready;
    is = !icache_ready;
    lu = memreadE && rdE != 0 && ((rs1_usedD && rdE == rs1D) || (rs2_usedD && rdE == rs2D));
    if (rst)                                  c = 0;
    else if (ms)                              c = 1;
    else if (m_pend && !is)                   c = 2;
    else if (branch_takenE && !m_pend && !is) c = 3;
    else if (branch_takenE && !m_pend)        c = 4;
    else if (lu)                              c = 5;
    else if (is)                              c = 6;
    else                                      c = 0;
    e_sF = (c == 1) || (c == 4) || (c == 5) || (c == 6);
    e_sD = (c == 1) || (c == 5);
    e_sE = (c == 1);
    e_sM = (c == 1);
    e_fD = (c == 2) || (c == 3) || (c == 4) || (c == 6);
    e_fE = (c == 3) || (c == 4) || (c == 5);
    e_fW = (c == 1);
    e_rv = (c == 2) || (c == 3);
    e_pc = (c == 2) ? m_pc : (c == 3) ? int'(branch_targetE) : 0;
    if (m_valid) begin
      chk("stallF", {31'd0, stallF}, {31'd0, e_sF});
      chk("stallD", {31'd0, stallD}, {31'd0, e_sD});
      chk("stallE", {31'd0, stallE}, {31'd0, e_sE});
      chk("stallM", {31'd0, stallM}, {31'd0, e_sM});
      chk("flushD", {31'd0, flushD}, {31'd0, e_fD});
      chk("flushE", {31'd0, flushE}, {31'd0, e_fE});
      chk("flushW", {31'd0, flushW}, {31'd0, e_fW});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_rv});
      chk("redirect_pc", redirect_pc, e_pc);
      chk("state", {30'd0, state}, m_state);
      chk("stall_cnt", {26'd0, stall_cnt}, m_scnt);
      chk("flush_cnt", {26'd0, flush_cnt}, m_fcnt);
    end
    if (rst) begin
      n_pend = 0; n_pc = 0; n_state = 0; n_scnt = 0; n_fcnt = 0;
    end else begin
      n_pend  = (c == 2) ? 0 : (c == 4) ? 1 : m_pend;
      n_pc    = (c == 4) ? int'(branch_targetE) : m_pc;
      n_state = ms ? 3 : n_pend ? 2 : is ? 1 : 0;
      n_scnt  = (e_sF && m_scnt < CMAX) ? m_scnt + 1 : m_scnt;
      n_fcnt  = ((c == 3 || c == 4) && m_fcnt < CMAX) ? m_fcnt + 1 : m_fcnt;
    end
    n_valid = m_valid || rst;
  end

  always @(posedge clk) begin
    m_pend  <= n_pend;
    m_pc    <= n_pc;
    m_state <= n_state;
    m_scnt  <= n_scnt;
    m_fcnt  <= n_fcnt;
    m_valid <= n_valid;
  end

  task automatic idle();
    rst = 0; icache_ready = 1; branch_takenE = 0; branch_targetE = '0;
    dcache_reqM = 0; dcache_ready = 0; memreadE = 0; rdE = 0;
    rs1D = 0; rs2D = 0; rs1_usedD = 0; rs2_usedD = 0;
  endtask

  task automatic settle(); @(negedge clk); endtask
  task automatic adv(); @(posedge clk); #1; endtask

  task automatic do_reset();
    idle(); rst = 1; adv(); rst = 0;
  endtask

  initial begin
    idle(); rst = 1;
    settle();
    chk("rst_stallF", {31'd0, stallF}, 32'd0);
    chk("rst_flushD", {31'd0, flushD}, 32'd0);
    adv(); rst = 0;
    settle();
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_stall_cnt", {26'd0, stall_cnt}, 32'd0);
    chk("reset_flush_cnt", {26'd0, flush_cnt}, 32'd0);
    adv();

    $display("[TB] scenario load-use");
    do_reset();
    memreadE = 1; rdE = 5; rs1D = 5; rs1_usedD = 1;
    settle();
    chk("lu_stallF", {31'd0, stallF}, 32'd1);
    chk("lu_stallD", {31'd0, stallD}, 32'd1);
    chk("lu_flushE", {31'd0, flushE}, 32'd1);
    adv(); memreadE = 0;
    settle();
    chk("lu_after_stallF", {31'd0, stallF}, 32'd0);
    chk("lu_stall_cnt", {26'd0, stall_cnt}, 32'd1);
    adv(); memreadE = 1; rdE = 0; rs1D = 0;
    settle();
    chk("lu_x0_stallF", {31'd0, stallF}, 32'd0);
    adv();

    $display("[TB] scenario dcache miss");
    do_reset();
    dcache_reqM = 1; dcache_ready = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("dmiss_stallM", {31'd0, stallM}, 32'd1);
      chk("dmiss_flushW", {31'd0, flushW}, 32'd1);
      adv();
    end
    dcache_ready = 1;
    settle();
    chk("drel_stallF", {31'd0, stallF}, 32'd0);
    chk("drel_state", {30'd0, state}, 32'd3);
    chk("drel_stall_cnt", {26'd0, stall_cnt}, 32'd4);
    adv();

    $display("[TB] scenario dcache miss with load-use");
    do_reset();
    dcache_reqM = 1; dcache_ready = 0; memreadE = 1; rdE = 5; rs1D = 5; rs1_usedD = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("dmlu_flushE", {31'd0, flushE}, 32'd0);
      chk("dmlu_stallM", {31'd0, stallM}, 32'd1);
      adv();
    end
    dcache_ready = 1;
    settle();
    chk("dmlu_rel_flushE", {31'd0, flushE}, 32'd1);
    chk("dmlu_rel_stallM", {31'd0, stallM}, 32'd0);
    adv();

    $display("[TB] scenario taken branch");
    do_reset();
    branch_takenE = 1; branch_targetE = 32'h100;
    settle();
    chk("br_rv", {31'd0, redirect_valid}, 32'd1);
    chk("br_pc", redirect_pc, 32'h100);
    chk("br_flushD", {31'd0, flushD}, 32'd1);
    chk("br_flushE", {31'd0, flushE}, 32'd1);
    adv(); idle();
    settle();
    chk("br_flush_cnt", {26'd0, flush_cnt}, 32'd1);
    adv();

    $display("[TB] scenario branch during icache miss");
    do_reset();
    icache_ready = 0; branch_takenE = 1; branch_targetE = 32'h200;
    settle();
    chk("ibr_flushE", {31'd0, flushE}, 32'd1);
    chk("ibr_rv", {31'd0, redirect_valid}, 32'd0);
    adv(); branch_takenE = 0;
    settle();
    chk("ibr_state", {30'd0, state}, 32'd2);
    chk("ibr_wait_flushD", {31'd0, flushD}, 32'd1);
    adv(); adv();
    icache_ready = 1;
    settle();
    chk("ibr_rel_rv", {31'd0, redirect_valid}, 32'd1);
    chk("ibr_rel_pc", redirect_pc, 32'h200);
    chk("ibr_rel_flushE", {31'd0, flushE}, 32'd0);
    adv(); idle();
    settle();
    chk("ibr_done_state", {30'd0, state}, 32'd0);
    chk("ibr_done_rv", {31'd0, redirect_valid}, 32'd0);
    adv();

    $display("[TB] scenario mstall versus redirect");
    do_reset();
    dcache_reqM = 1; dcache_ready = 0; branch_takenE = 1; branch_targetE = 32'h300;
    settle();
    chk("msbr_rv", {31'd0, redirect_valid}, 32'd0);
    chk("msbr_stallE", {31'd0, stallE}, 32'd1);
    adv(); dcache_ready = 1;
    settle();
    chk("msbr_rel_pc", redirect_pc, 32'h300);
    adv(); idle(); icache_ready = 0; branch_takenE = 1; branch_targetE = 32'h400;
    adv(); idle(); dcache_reqM = 1;
    settle();
    chk("mspend_rv", {31'd0, redirect_valid}, 32'd0);
    chk("mspend_stallM", {31'd0, stallM}, 32'd1);
    adv(); dcache_ready = 1;
    settle();
    chk("mspend_rel_rv", {31'd0, redirect_valid}, 32'd1);
    chk("mspend_rel_pc", redirect_pc, 32'h400);
    adv();

    $display("[TB] scenario counter saturation");
    do_reset();
    icache_ready = 0;
    repeat (CMAX - 1) adv();
    settle();
    chk("sat_pre", {26'd0, stall_cnt}, CMAX - 1);
    repeat (3) adv();
    idle();
    settle();
    chk("sat_max", {26'd0, stall_cnt}, CMAX);
    adv();

    $display("[TB] scenario reset during pending redirect");
    do_reset();
    icache_ready = 0; branch_takenE = 1; branch_targetE = 32'h500;
    adv(); branch_takenE = 0;
    settle();
    chk("rstp_state", {30'd0, state}, 32'd2);
    adv(); rst = 1; icache_ready = 1;
    settle();
    chk("rstp_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rstp_flushD", {31'd0, flushD}, 32'd0);
    adv(); rst = 0;
    settle();
    chk("rstp_after_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rstp_after_state", {30'd0, state}, 32'd0);
    chk("rstp_after_scnt", {26'd0, stall_cnt}, 32'd0);
    chk("rstp_after_fcnt", {26'd0, flush_cnt}, 32'd0);
    adv();

    $display("[TB] scenario random traffic");
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      icache_ready   = ($urandom_range(0, 3) != 0);
      branch_takenE  = !m_pend && ($urandom_range(0, 5) == 0);
      branch_targetE = $urandom;
      dcache_reqM    = ($urandom_range(0, 2) == 0);
      dcache_ready   = $urandom_range(0, 1) == 1;
      memreadE       = $urandom_range(0, 1) == 1;
      rdE            = 5'($urandom_range(0, 7));
      rs1D           = 5'($urandom_range(0, 7));
      rs2D           = 5'($urandom_range(0, 7));
      rs1_usedD      = $urandom_range(0, 1) == 1;
      rs2_usedD      = $urandom_range(0, 1) == 1;
      adv();
    end
    idle();
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Issues pipeline stall, flush and redirect controls for the 5-stage core. It covers every case the operand-forwarding network cannot resolve: load-use, I-cache miss, D-cache miss and taken branch.
- Sits beside the forwarding unit. It consumes decode/execute register indices and cache ready handshakes.
- Holds a pending branch redirect across an I-cache miss and keeps performance counters.

Parameters:
- CNT_W, 32, width of the saturating stall and flush performance counters.
- XLEN, 32, PC width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- rs1D  input  5  decode-stage source register 1.
- rs2D  input  5  decode-stage source register 2.
- rs1_usedD  input  1  decode instruction reads rs1.
- rs2_usedD  input  1  decode instruction reads rs2.
- rdE  input  5  execute-stage destination register.
- memreadE  input  1  execute instruction is a load.
- branch_takenE  input  1  execute-stage branch/jump resolved taken.
- branch_targetE  input  XLEN  target of that branch.
- icache_ready  input  1  fetch data valid this cycle.
- dcache_reqM  input  1  memory stage issues a load/store.
- dcache_ready  input  1  D-cache completes the request this cycle.
- stallF, stallD, stallE, stallM  output  1 each  hold the corresponding pipeline register.
- flushD, flushE, flushW  output  1 each  load a bubble into the corresponding register.
- redirect_valid  output  1  PC mux selects redirect_pc.
- redirect_pc  output  XLEN  redirect target.
- stall_cnt  output  CNT_W  cycles with stallF=1, saturating at all-ones.
- flush_cnt  output  CNT_W  cycles with flushE=1 due to a branch, saturating.
- state  output  2  0=RUN, 1=IWAIT, 2=IWAIT_REDIR, 3=DWAIT (debug).

Behaviour:
- Term definitions:
  - mstall = dcache_reqM & ~dcache_ready.
  - istall = ~icache_ready.
  - lu = memreadE & rdE!=0 & ((rs1_usedD & rdE==rs1D) | (rs2_usedD & rdE==rs2D)).
- Outputs are combinational from inputs, pend_v and pend_pc. Registers are pend_v, pend_pc, state and the two counters.
- Priority, highest first; unlisted outputs are 0:
  1. mstall: stallF=stallD=stallE=stallM=1, flushW=1. Branch and lu are ignored this cycle; E is held, so both are re-evaluated on release. pend_v holds.
  2. pend_v & icache_ready: redirect_valid=1, redirect_pc=pend_pc, flushD=1 to discard the wrong-path fetch. pend_v clears at the edge.
  3. branch_takenE & ~istall: redirect_valid=1, redirect_pc=branch_targetE, flushD=1, flushE=1.
  4. branch_takenE & istall: flushD=1, flushE=1, stallF=1. pend_v<=1 and pend_pc<=branch_targetE at the edge. redirect_valid=0.
  5. lu: stallF=stallD=1, flushE=1. Exactly one bubble per load-use; the next cycle forwarding covers the value.
  6. istall (including pend_v waiting): stallF=1, flushD=1; downstream stages advance.
- Case 5 is unreachable while pend_v=1, because D/E were flushed.
- branch_takenE while pend_v=1 cannot occur. The bench asserts this; the RTL gives the pending redirect priority.
- State register, next-state evaluated each edge:
  - DWAIT if mstall.
  - else IWAIT_REDIR if next pend_v.
  - else IWAIT if istall.
  - else RUN.
- Counters:
  - stall_cnt increments when stallF=1.
  - flush_cnt increments when case 3 or 4 fires.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset (synchronous, rst=1 at edge): pend_v=0, pend_pc=0, state=RUN, stall_cnt=0, flush_cnt=0.
- While rst is asserted all stall/flush/redirect outputs are forced to 0. A mid-miss reset discards the pending redirect.
- Latency: all control outputs are zero-cycle relative to their inputs. A pending redirect appears in the same cycle icache_ready rises.
- dcache_ready without dcache_reqM is ignored.

Test Plan:
- lw x5 in E (memreadE=1, rdE=5), add in D with rs1D=5, rs1_usedD=1 -> exactly one cycle of stallF=stallD=flushE=1, then all 0; stall_cnt=1. Repeat with rdE=0 -> no stall.
- dcache_reqM=1, dcache_ready low 4 cycles -> stallF..stallM=1 and flushW=1 for 4 cycles, state=DWAIT; release cycle all 0; stall_cnt=4. Same window with lu true -> lu bubble occurs only after release.
- branch_takenE=1, target 0x0000_0100, icache_ready=1 -> same cycle redirect_valid=1, redirect_pc=0x100, flushD=flushE=1; flush_cnt=1.
- icache_ready=0 for 3 cycles; branch_takenE=1 to 0x200 in first cycle -> flushD/E that cycle, state=IWAIT_REDIR; on icache_ready=1: redirect_valid=1, pc=0x200, flushD=1; next cycle pend_v=0, state=RUN.
- mstall and branch_takenE together, and pend_v with mstall -> memory stall wins, no redirect; the redirect fires after dcache_ready.
- Preload stall_cnt to all-ones minus 1, stall 3 cycles -> saturates at all-ones. Assert rst during IWAIT_REDIR -> next cycle all outputs 0, state=RUN, counters 0.
